// File: rtl/psm_pkg.sv
// Shared constants for the phase-shift bridge modulator.
package psm_pkg;
    localparam int BITS_DATA    = 16;
    localparam int DT_BITS      = 7;
    localparam int SPS_SIGN_BIT = 15;
    localparam int MIN_PERIOD   = 4;
endpackage

// File: rtl/psm_deadtime_pair.sv
// Converts one raw leg into a complementary high/low gate pair with dead time.
module psm_deadtime_pair #(
    parameter int DT_BITS = psm_pkg::DT_BITS
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               leg,
    input  logic [DT_BITS-1:0] dt,
    output logic               hi,
    output logic               lo
);
    logic               leg_q;
    logic [DT_BITS-1:0] run_q;
    logic [DT_BITS-1:0] run_eff;
    logic               settled;

    // Run length seen this cycle: an edge on the leg restarts it at zero,
    // so a gate only turns on once the leg has been stable for dt cycles.
    always_comb begin
        run_eff = (leg != leg_q) ? '0 : run_q;
        settled = (run_eff >= dt);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            leg_q <= 1'b0;
            run_q <= '0;
            hi    <= 1'b0;
            lo    <= 1'b0;
        end else begin
            leg_q <= leg;
            run_q <= (&run_eff) ? run_eff : run_eff + DT_BITS'(1);
            hi    <= leg & settled;
            lo    <= ~leg & settled;
        end
    end
endmodule

// File: rtl/psm_bridge_modulator.sv
// Phase-shift modulator for one full bridge: carrier, shadowed period/shift,
// leg generation and per-leg dead-time gate pairs.
module psm_bridge_modulator #(
    parameter int BITS_DATA = psm_pkg::BITS_DATA,
    parameter int DT_BITS   = psm_pkg::DT_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [BITS_DATA-1:0] i_period,
    input  logic [BITS_DATA-1:0] i_sps,
    input  logic [DT_BITS-1:0]   i_deadtime,
    input  logic                 i_sync,
    output logic [1:0]           o_leg,
    output logic [3:0]           o_gate
);
    localparam int SW = psm_pkg::SPS_SIGN_BIT;

    logic [BITS_DATA-1:0] cnt, per_q, half, mag_ext, se, dt_lim;
    logic [SW-1:0]        mag_q;
    logic                 dir_q, run, wrap, load;
    logic [BITS_DATA:0]   sum_b, ph_b;
    logic [1:0]           leg_d, hi, lo;
    logic [DT_BITS-1:0]   dt_eff;

    assign half    = per_q >> 1;
    assign mag_ext = BITS_DATA'(mag_q);
    assign se      = (mag_ext > half) ? half : mag_ext;
    assign run     = (per_q >= BITS_DATA'(psm_pkg::MIN_PERIOD));
    assign wrap    = (cnt == per_q - BITS_DATA'(1));
    // Shadows follow the inputs continuously while the generator is idle.
    assign load    = i_sync | ~run | wrap;

    always_comb begin
        sum_b = dir_q ? ({1'b0, cnt} + {1'b0, se})
                      : ({1'b0, cnt} + {1'b0, per_q} - {1'b0, se});
        ph_b  = (sum_b >= {1'b0, per_q}) ? sum_b - {1'b0, per_q} : sum_b;
        leg_d[0] = run & (cnt < half);
        leg_d[1] = run & (ph_b < {1'b0, half});
        dt_lim = (half == '0) ? '0 : half - BITS_DATA'(1);
        dt_eff = (BITS_DATA'(i_deadtime) > dt_lim) ? dt_lim[DT_BITS-1:0] : i_deadtime;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt   <= '0;
            per_q <= i_period;
            mag_q <= i_sps[SW-1:0];
            dir_q <= i_sps[SW];
            o_leg <= '0;
        end else begin
            if (load) begin
                per_q <= i_period;
                mag_q <= i_sps[SW-1:0];
                dir_q <= i_sps[SW];
            end
            cnt   <= load ? '0 : cnt + BITS_DATA'(1);
            o_leg <= leg_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_leg
        psm_deadtime_pair #(.DT_BITS(DT_BITS)) u_dt (
            .clk   (clk),
            .n_rst (n_rst),
            .leg   (o_leg[g]),
            .dt    (dt_eff),
            .hi    (hi[g]),
            .lo    (lo[g])
        );
    end

    assign o_gate = {lo[1], hi[1], lo[0], hi[0]};
endmodule

// File: tb/tb_psm_bridge_modulator.sv
// Directed bench for psm_bridge_modulator with hand-derived expected values.
module tb_psm_bridge_modulator;
    logic        clk;
    logic        n_rst;
    logic [15:0] i_period;
    logic [15:0] i_sps;
    logic [6:0]  i_deadtime;
    logic        i_sync;
    logic [1:0]  o_leg;
    logic [3:0]  o_gate;

    int n_cmp = 0;
    int n_err = 0;
    int n_ovl = 0;
    int k     = 0;

    psm_bridge_modulator dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_period   (i_period),
        .i_sps      (i_sps),
        .i_deadtime (i_deadtime),
        .i_sync     (i_sync),
        .o_leg      (o_leg),
        .o_gate     (o_gate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and track gate overlap.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if ((o_gate[0] & o_gate[1]) | (o_gate[2] & o_gate[3])) n_ovl++;
    endtask

    task automatic wait_to(input int n);
        while (k < n) tick();
    endtask

    task automatic do_reset(input logic [15:0] p, input logic [15:0] s, input logic [6:0] d);
        n_rst      = 1'b0;
        i_period   = p;
        i_sps      = s;
        i_deadtime = d;
        i_sync     = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        k     = 0;
    endtask

    initial begin
        int a_high;
        int n_eq;
        int n_nz;
        clk = 1'b0;
        n_rst = 1'b0;
        i_period = 16'd20;
        i_sps = 16'd0;
        i_deadtime = 7'd0;
        i_sync = 1'b0;

        // Reset state, P=20, no shift, no dead time
        do_reset(16'd20, 16'd0, 7'd0);
        chk("rst_leg", 8'(o_leg), 8'h00);
        chk("rst_gate", 8'(o_gate), 8'h00);
        tick();
        chk("dt0_k1_leg", 8'(o_leg), 8'b11);
        chk("dt0_k1_gate", 8'(o_gate), 8'b1010);
        tick();
        chk("dt0_k2_gate", 8'(o_gate), 8'b0101);
        wait_to(11);
        chk("dt0_k11_leg", 8'(o_leg), 8'b00);
        chk("dt0_k11_gate", 8'(o_gate), 8'b0101);
        tick();
        chk("dt0_k12_gate", 8'(o_gate), 8'b1010);
        a_high = 0;
        n_eq = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_leg[0]) a_high++;
            if (o_gate[0] == o_gate[1]) n_eq++;
        end
        chk("dt0_a_high_count", 8'(a_high), 8'd10);
        chk("dt0_hi_eq_lo", 8'(n_eq), 8'd0);

        // B lags A by 5
        do_reset(16'd20, 16'd5, 7'd0);
        wait_to(5);  chk("lag5_k5", 8'(o_leg), 8'b01);
        tick();      chk("lag5_k6", 8'(o_leg), 8'b11);
        wait_to(11); chk("lag5_k11", 8'(o_leg), 8'b10);
        wait_to(16); chk("lag5_k16", 8'(o_leg), 8'b00);

        // B leads A by 5
        do_reset(16'd20, 16'h8005, 7'd0);
        wait_to(5);  chk("lead5_k5", 8'(o_leg), 8'b11);
        tick();      chk("lead5_k6", 8'(o_leg), 8'b01);
        wait_to(15); chk("lead5_k15", 8'(o_leg), 8'b00);
        tick();      chk("lead5_k16", 8'(o_leg), 8'b10);
        wait_to(21); chk("lead5_k21", 8'(o_leg), 8'b11);

        // Shift 15 clamps to half period: B = ~A
        do_reset(16'd20, 16'd15, 7'd0);
        tick();      chk("clamp_k1", 8'(o_leg), 8'b01);
        wait_to(11); chk("clamp_k11", 8'(o_leg), 8'b10);
        wait_to(20); chk("clamp_k20", 8'(o_leg), 8'b10);
        tick();      chk("clamp_k21", 8'(o_leg), 8'b01);

        // Dead time 3
        do_reset(16'd20, 16'd0, 7'd3);
        tick();      chk("dt3_k1", 8'(o_gate), 8'b0000);
        wait_to(4);  chk("dt3_k4", 8'(o_gate), 8'b0000);
        tick();      chk("dt3_k5", 8'(o_gate), 8'b0101);
        wait_to(11); chk("dt3_k11", 8'(o_gate), 8'b0101);
        tick();      chk("dt3_k12", 8'(o_gate), 8'b0000);
        wait_to(14); chk("dt3_k14", 8'(o_gate), 8'b0000);
        tick();      chk("dt3_k15", 8'(o_gate), 8'b1010);
        wait_to(21); chk("dt3_k21", 8'(o_gate), 8'b1010);
        tick();      chk("dt3_k22", 8'(o_gate), 8'b0000);
        wait_to(25); chk("dt3_k25", 8'(o_gate), 8'b0101);

        // Dead time 100 clamps to 9: one-cycle gate pulses
        do_reset(16'd20, 16'd0, 7'd100);
        wait_to(10); chk("dt100_k10", 8'(o_gate), 8'b0000);
        tick();      chk("dt100_k11", 8'(o_gate), 8'b0101);
        tick();      chk("dt100_k12", 8'(o_gate), 8'b0000);
        wait_to(20); chk("dt100_k20", 8'(o_gate), 8'b0000);
        tick();      chk("dt100_k21", 8'(o_gate), 8'b1010);
        tick();      chk("dt100_k22", 8'(o_gate), 8'b0000);

        // Period change 20->40 mid-period takes effect at the wrap
        do_reset(16'd20, 16'd0, 7'd0);
        wait_to(5);
        i_period = 16'd40;
        wait_to(20); chk("per_k20", 8'(o_leg), 8'b00);
        tick();      chk("per_k21", 8'(o_leg), 8'b11);
        wait_to(40); chk("per_k40", 8'(o_leg), 8'b11);
        tick();      chk("per_k41", 8'(o_leg), 8'b00);
        wait_to(60); chk("per_k60", 8'(o_leg), 8'b00);
        tick();      chk("per_k61", 8'(o_leg), 8'b11);

        // Sync at cnt=7 restarts the carrier
        wait_to(67);
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        chk("sync_k68", 8'(o_leg), 8'b11);
        wait_to(81); chk("sync_k81", 8'(o_leg), 8'b11);
        wait_to(88); chk("sync_k88", 8'(o_leg), 8'b11);
        tick();      chk("sync_k89", 8'(o_leg), 8'b00);

        // Reset while legs are high, then dead time 3 after release
        wait_to(110);
        chk("pre_rst_leg", 8'(o_leg), 8'b11);
        chk("pre_rst_gate", 8'(o_gate), 8'b0101);
        n_rst = 1'b0;
        i_period = 16'd20;
        i_deadtime = 7'd3;
        tick();
        chk("mid_rst_leg", 8'(o_leg), 8'b00);
        chk("mid_rst_gate", 8'(o_gate), 8'b0000);
        n_rst = 1'b1;
        k = 0;
        tick();      chk("post_rst_k1", 8'(o_gate), 8'b0000);
        wait_to(4);  chk("post_rst_k4", 8'(o_gate), 8'b0000);
        tick();      chk("post_rst_k5", 8'(o_gate), 8'b0101);

        // P=2 disables the generator
        do_reset(16'd2, 16'd0, 7'd0);
        n_nz = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_leg != 2'b00) n_nz++;
        end
        chk("p2_leg_nonzero", 8'(n_nz), 8'd0);
        chk("p2_gate", 8'(o_gate), 8'b1010);

        chk("gate_overlap", 8'(n_ovl), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
